data_mem_sync: RTL and testbench
================================

# data_mem_sync

Parametrised successor to the processor's data memory. Adds:
- configurable word width and depth;
- selectable combinational or registered read path, with a read-valid strobe;
- defined read/write collision policy;
- a hardware clear sequencer that zeroes every word after reset or on request.

It sits between the execute stage and writeback, on the load/store path.

## Interface
Parameters:
- `WIDTH`, 8: data word width in bits.
- `DEPTH`, 256: number of words, power of two, ≥ 4; `AW = $clog2(DEPTH)`.
- `READ_LAT`, 1: 0 = combinational read, 1 = registered read.
- `WR_FIRST`, 1: collision policy for `READ_LAT=1`; 1 = new data, 0 = old data.

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `clr`  in  1: request a full zeroing of the memory.
- `memWrt`  in  1: write enable.
- `wrAddr`  in  `AW`: write address.
- `wrData`  in  `WIDTH`: write data.
- `rdEn`  in  1: read request.
- `rdAddr`  in  `AW`: read address.
- `memOut`  out  `WIDTH`: read data.
- `rdValid`  out  1: `memOut` holds the result of an accepted read.
- `busy`  out  1: clear sequencer active; write and read requests are dropped.

## Operation
- State machine, enum `{CLEAR, READY}`:
  - `reset` → `CLEAR`, clear counter = 0.
  - `CLEAR`: writes 0 to `Core[cnt]` and increments `cnt` each cycle. At `cnt == DEPTH-1`, performs that write and moves to `READY`.
  - `READY`: `clr=1` → `CLEAR`, `cnt = 0`. Otherwise serves requests.
- `busy = (state == CLEAR)`.
- Write, `READY` only: `memWrt=1` writes `wrData` to `Core[wrAddr]` at the edge.
- Read, `READY` only, `rdEn=1`:
  - `READ_LAT=0`: `memOut = Core[rdAddr]` combinationally; `rdValid = rdEn && !busy`, same cycle.
  - `READ_LAT=1`: `memOut` is registered from `Core[rdAddr]` at the edge; `rdValid` is registered high for exactly one cycle. When no read is accepted, `memOut` holds its last value and `rdValid=0`.
- Collision, same-cycle write and read with `rdAddr == wrAddr`:
  - `READ_LAT=0`: returns old contents; the write lands at the edge.
  - `READ_LAT=1, WR_FIRST=1`: returns `wrData` (bypass).
  - `READ_LAT=1, WR_FIRST=0`: returns old contents.
- Requests during `busy`: writes are discarded, reads produce no `rdValid`.
- `clr` while already in `CLEAR` is ignored; the sweep does not restart.
- `reset` mid-clear restarts the sweep from address 0.
- `reset` has priority over `clr`; `clr` has priority over a same-cycle request, which is dropped.

## Timing
- Reset values: `busy=1`, `rdValid=0`, `memOut=0` (`READ_LAT=1` register; with `READ_LAT=0` the output follows memory).
- Clear duration is exactly `DEPTH` cycles after `reset` or `clr` deasserts.
  - The first `READY` cycle is cycle `DEPTH` after the reset edge; `busy` falls then.
- Write latency: 1 edge. A read in the following cycle sees the new data.
- Read latency: 0 cycles (`READ_LAT=0`) or 1 cycle (`READ_LAT=1`).
- Back-to-back reads every cycle are supported at full throughput.
- Address counter is `AW` bits. The terminal compare is `DEPTH-1`, so the counter never wraps into a second pass.

## Structure
- Shared package `data_mem_pkg` holds:
  - the `mem_state_t` enum `{CLEAR, READY}`;
  - default `WIDTH`/`DEPTH` constants, kept consistent with the `byteW`/`memW` definitions.
- Sub-module `data_mem_clr_seq` holds the state register, counter and `busy`.
  - It emits `clrWe` and `clrAddr`, which the top muxes onto the write port.
- Top module holds the storage array, the read path and collision muxing.

## Test plan
- **Reset sweep:** preload all words with 0xA5, pulse `reset` one cycle.
  - `busy=1` for exactly 256 cycles.
  - Reads issued during the sweep give `rdValid=0`.
  - Afterwards, reads of 0, 128, 255 return 0x00.
- **Basic write/read, `READ_LAT=1`:** write 0x3C to address 7, then `rdEn` with `rdAddr=7` on the next cycle.
  - Result: `memOut=0x3C` and `rdValid=1` one cycle later, `rdValid` low the cycle after.
- **Collision:** address 9 holds 0x11; same cycle, write 0x22 to 9 and read 9.
  - `WR_FIRST=1` → 0x22.
  - `WR_FIRST=0` → 0x11.
  - `READ_LAT=0` → 0x11 in the same cycle.
- **Runtime clear:** at steady state, assert `clr` together with a write of 0xFF to address 3.
  - Write is dropped and `busy` rises next cycle.
  - After 256 cycles, address 3 reads 0x00.
- **Reset mid-clear:** assert `reset` at sweep cycle 100.
  - `busy` stays high 256 more cycles after `reset` deasserts, not 156.
- **Parametrisation:** `WIDTH=16, DEPTH=16`.
  - Clear takes 16 cycles.
  - Write 0xBEEF to address 15; reading it back returns 0xBEEF.
  - Address 0 still reads 0x0000.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the parametrised data memory: controller states and
// default geometry matching the original byte-wide, 256-word memory.
package data_mem_pkg;

  // Geometry of the original data memory (byte words, 256 entries)
  localparam int byteW = 8;
  localparam int memW  = 256;

  // Defaults for the parametrised memory track the original geometry
  localparam int DEFAULT_WIDTH = byteW;
  localparam int DEFAULT_DEPTH = memW;

  // Controller state: sweeping zeros through the array, or serving requests
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/data_mem_clr_seq.sv
// Clear sequencer: owns the CLEAR/READY state, the sweep address counter and
// the busy flag, and presents a zero-write request for the top to mux in.
module data_mem_clr_seq
  import data_mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clr_i,
  output logic          busy_o,
  output logic          clrWe_o,
  output logic [AW-1:0] clrAddr_o
);

  // Last address of the sweep; the counter stops here and never wraps
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  mem_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // State and sweep counter registers; reset restarts the sweep at address 0
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: walk every address once, then serve until a clear request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == LastAddr) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        if (clr_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: while clearing, write zero to the current sweep address
  always_comb begin
    busy_o    = (state_q == CLEAR);
    clrWe_o   = (state_q == CLEAR);
    clrAddr_o = cnt_q;
  end

endmodule

// File: rtl/data_mem_sync.sv
// Parametrised load/store data memory with selectable read latency, a defined
// read/write collision policy and a hardware clear sweep after reset or clr.
module data_mem_sync
  import data_mem_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int READ_LAT = 1,
  parameter int WR_FIRST = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             memWrt,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdEn,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] memOut,
  output logic             rdValid,
  output logic             busy
);

  logic             clrWe;
  logic [AW-1:0]    clrAddr;
  logic             reqOk;
  logic             userWe;
  logic             portWe;
  logic [AW-1:0]    portAddr;
  logic [WIDTH-1:0] portData;

  logic [WIDTH-1:0] core_q [DEPTH];

  data_mem_clr_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) uClrSeq (
    .clk_i     (clk),
    .reset_i   (reset),
    .clr_i     (clr),
    .busy_o    (busy),
    .clrWe_o   (clrWe),
    .clrAddr_o (clrAddr)
  );

  // Requests are only honoured when ready and not pre-empted by reset or clr
  always_comb begin
    reqOk  = !busy && !clr && !reset;
    userWe = memWrt && reqOk;
  end

  // Single write port: the clear sweep owns it while busy, else the user does
  always_comb begin
    portWe   = clrWe || userWe;
    portAddr = clrWe ? clrAddr : wrAddr;
    portData = clrWe ? '0 : wrData;
  end

  // Storage array; contents are defined by the clear sweep, not by reset
  always_ff @(posedge clk) begin
    if (portWe) begin
      core_q[portAddr] <= portData;
    end
  end

  generate
    if (READ_LAT == 0) begin : gCombRead
      // Combinational read returns pre-edge contents, so collisions see old data
      always_comb begin
        memOut  = core_q[rdAddr];
        rdValid = rdEn && !busy;
      end
    end else begin : gRegRead
      logic             rdAccept;
      logic             bypass;
      logic [WIDTH-1:0] memOut_d;
      logic [WIDTH-1:0] memOut_q;
      logic             rdValid_q;

      // Read data select: forward same-cycle write data when write-first
      always_comb begin
        rdAccept = rdEn && reqOk;
        bypass   = (WR_FIRST != 0) && userWe && (wrAddr == rdAddr);
        memOut_d = bypass ? wrData : core_q[rdAddr];
      end

      // Output register holds its value between accepted reads
      always_ff @(posedge clk) begin
        if (reset) begin
          memOut_q  <= '0;
          rdValid_q <= 1'b0;
        end else begin
          rdValid_q <= rdAccept;
          if (rdAccept) begin
            memOut_q <= memOut_d;
          end
        end
      end

      // Drive the registered read result onto the ports
      always_comb begin
        memOut  = memOut_q;
        rdValid = rdValid_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_sync.sv
// Directed bench for data_mem_sync: three 8x256 instances share stimulus
// (write-first registered, read-first registered, combinational) and a
// fourth 16x16 instance exercises the parametrisation.
module tb_data_mem_sync;

  logic       clk = 1'b0;
  logic       reset, clr, memWrt, rdEn;
  logic [7:0] wrAddr, rdAddr, wrData;

  logic [7:0] memOutA, memOutB, memOutC;
  logic       rdValidA, rdValidB, rdValidC;
  logic       busyA, busyB, busyC;

  logic        dReset, dClr, dMemWrt, dRdEn;
  logic [3:0]  dWrAddr, dRdAddr;
  logic [15:0] dWrData, dMemOut;
  logic        dRdValid, dBusy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_mem_sync #(.WIDTH(8), .DEPTH(256), .READ_LAT(1), .WR_FIRST(1)) dutA (
    .clk(clk), .reset(reset), .clr(clr), .memWrt(memWrt), .wrAddr(wrAddr),
    .wrData(wrData), .rdEn(rdEn), .rdAddr(rdAddr), .memOut(memOutA),
    .rdValid(rdValidA), .busy(busyA)
  );

  data_mem_sync #(.WIDTH(8), .DEPTH(256), .READ_LAT(1), .WR_FIRST(0)) dutB (
    .clk(clk), .reset(reset), .clr(clr), .memWrt(memWrt), .wrAddr(wrAddr),
    .wrData(wrData), .rdEn(rdEn), .rdAddr(rdAddr), .memOut(memOutB),
    .rdValid(rdValidB), .busy(busyB)
  );

  data_mem_sync #(.WIDTH(8), .DEPTH(256), .READ_LAT(0), .WR_FIRST(1)) dutC (
    .clk(clk), .reset(reset), .clr(clr), .memWrt(memWrt), .wrAddr(wrAddr),
    .wrData(wrData), .rdEn(rdEn), .rdAddr(rdAddr), .memOut(memOutC),
    .rdValid(rdValidC), .busy(busyC)
  );

  data_mem_sync #(.WIDTH(16), .DEPTH(16), .READ_LAT(1), .WR_FIRST(1)) dutD (
    .clk(clk), .reset(dReset), .clr(dClr), .memWrt(dMemWrt), .wrAddr(dWrAddr),
    .wrData(dWrData), .rdEn(dRdEn), .rdAddr(dRdAddr), .memOut(dMemOut),
    .rdValid(dRdValid), .busy(dBusy)
  );

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles with busy high on the 8-bit instances, bounded
  task automatic waitReady(output int n);
    n = 0;
    while (busyA === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
  endtask

  // Registered read on the shared bus, leaves rdValid/memOut of A/B sampled
  task automatic regRead(input logic [7:0] addr);
    rdEn   = 1'b1;
    rdAddr = addr;
    tick();
    rdEn   = 1'b0;
  endtask

  task automatic doWrite(input logic [7:0] addr, input logic [7:0] data);
    memWrt = 1'b1;
    wrAddr = addr;
    wrData = data;
    tick();
    memWrt = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    dReset = 1'b1;
    tick();
    checks++;
    if (busyA !== 1'b1 || rdValidA !== 1'b0 || memOutA !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_values: busy=%b rdValid=%b memOut=%h expected 1 0 00", busyA, rdValidA, memOutA);
    end
    reset = 1'b0;
    dReset = 1'b0;
    waitReady(n);
    checks++;
    if (n != 256) begin
      errors++;
      $display("[TB] FAIL initial_clear_len: got %0d expected 256", n);
    end
  endtask

  task automatic test_reset_sweep();
    int  n;
    logic sawValid;
    for (int i = 0; i < 256; i++) begin
      doWrite(8'(i), 8'hA5);
    end
    regRead(8'd128);
    checks++;
    if (memOutA !== 8'hA5 || rdValidA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL preload_read: memOut=%h rdValid=%b expected a5 1", memOutA, rdValidA);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    sawValid = 1'b0;
    rdEn = 1'b1;
    while (busyA === 1'b1 && n < 1000) begin
      rdAddr = 8'(n * 7);
      #1;
      if (rdValidA !== 1'b0 || rdValidB !== 1'b0 || rdValidC !== 1'b0) sawValid = 1'b1;
      n++;
      tick();
    end
    rdEn = 1'b0;
    checks++;
    if (n != 256) begin
      errors++;
      $display("[TB] FAIL reset_sweep_len: got %0d expected 256", n);
    end
    checks++;
    if (sawValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sweep_rdvalid: got %b expected 0", sawValid);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] a;
      a = (k == 0) ? 8'd0 : (k == 1) ? 8'd128 : 8'd255;
      rdEn = 1'b1;
      rdAddr = a;
      #1;
      checks++;
      if (memOutC !== 8'h00 || rdValidC !== 1'b1) begin
        errors++;
        $display("[TB] FAIL cleared_comb_%0d: memOut=%h rdValid=%b expected 00 1", a, memOutC, rdValidC);
      end
      tick();
      rdEn = 1'b0;
      checks++;
      if (memOutA !== 8'h00 || rdValidA !== 1'b1) begin
        errors++;
        $display("[TB] FAIL cleared_reg_%0d: memOut=%h rdValid=%b expected 00 1", a, memOutA, rdValidA);
      end
    end
  endtask

  task automatic test_write_read();
    doWrite(8'd7, 8'h3C);
    regRead(8'd7);
    checks++;
    if (memOutA !== 8'h3C || rdValidA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_read: memOut=%h rdValid=%b expected 3c 1", memOutA, rdValidA);
    end
    rdAddr = 8'd0;
    tick();
    checks++;
    if (rdValidA !== 1'b0 || memOutA !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL basic_hold: memOut=%h rdValid=%b expected 3c 0", memOutA, rdValidA);
    end
  endtask

  task automatic test_collision();
    doWrite(8'd9, 8'h11);
    memWrt = 1'b1;
    wrAddr = 8'd9;
    wrData = 8'h22;
    rdEn   = 1'b1;
    rdAddr = 8'd9;
    #1;
    checks++;
    if (memOutC !== 8'h11) begin
      errors++;
      $display("[TB] FAIL collision_comb: got %h expected 11", memOutC);
    end
    tick();
    memWrt = 1'b0;
    rdEn   = 1'b0;
    checks++;
    if (memOutA !== 8'h22) begin
      errors++;
      $display("[TB] FAIL collision_wrfirst: got %h expected 22", memOutA);
    end
    checks++;
    if (memOutB !== 8'h11) begin
      errors++;
      $display("[TB] FAIL collision_rdfirst: got %h expected 11", memOutB);
    end
    regRead(8'd9);
    checks++;
    if (memOutB !== 8'h22 || memOutC !== 8'h22) begin
      errors++;
      $display("[TB] FAIL collision_landed: B=%h C=%h expected 22 22", memOutB, memOutC);
    end
  endtask

  task automatic test_back_to_back();
    doWrite(8'd20, 8'h01);
    doWrite(8'd21, 8'h02);
    doWrite(8'd22, 8'h03);
    rdEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rdAddr = 8'(20 + i);
      tick();
      checks++;
      if (memOutA !== 8'(i + 1) || rdValidA !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_%0d: memOut=%h rdValid=%b expected %h 1", i, memOutA, rdValidA, 8'(i + 1));
      end
    end
    rdEn = 1'b0;
    tick();
  endtask

  task automatic test_runtime_clear();
    int n;
    doWrite(8'd3, 8'h5A);
    clr    = 1'b1;
    memWrt = 1'b1;
    wrAddr = 8'd3;
    wrData = 8'hFF;
    tick();
    clr    = 1'b0;
    memWrt = 1'b0;
    checks++;
    if (busyA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr_busy_rise: got %b expected 1", busyA);
    end
    waitReady(n);
    checks++;
    if (n != 256) begin
      errors++;
      $display("[TB] FAIL clr_len: got %0d expected 256", n);
    end
    regRead(8'd3);
    checks++;
    if (memOutA !== 8'h00 || rdValidA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr_addr3: memOut=%h rdValid=%b expected 00 1", memOutA, rdValidA);
    end
    regRead(8'd7);
    checks++;
    if (memOutA !== 8'h00) begin
      errors++;
      $display("[TB] FAIL clr_addr7: got %h expected 00", memOutA);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    waitReady(n);
    checks++;
    if (n != 256) begin
      errors++;
      $display("[TB] FAIL reset_mid_clear_len: got %0d expected 256", n);
    end
  endtask

  task automatic test_clr_during_clear();
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    waitReady(n);
    checks++;
    if (n != 205) begin
      errors++;
      $display("[TB] FAIL clr_ignored_len: got %0d expected 205", n);
    end
  endtask

  task automatic test_param16();
    int n;
    dReset = 1'b1;
    tick();
    dReset = 1'b0;
    n = 0;
    while (dBusy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("[TB] FAIL p16_clear_len: got %0d expected 16", n);
    end
    dMemWrt = 1'b1;
    dWrAddr = 4'd15;
    dWrData = 16'hBEEF;
    tick();
    dMemWrt = 1'b0;
    dRdEn   = 1'b1;
    dRdAddr = 4'd15;
    tick();
    checks++;
    if (dMemOut !== 16'hBEEF || dRdValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL p16_read15: memOut=%h rdValid=%b expected beef 1", dMemOut, dRdValid);
    end
    dRdAddr = 4'd0;
    tick();
    dRdEn = 1'b0;
    checks++;
    if (dMemOut !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL p16_read0: got %h expected 0000", dMemOut);
    end
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; memWrt = 1'b0; rdEn = 1'b0;
    wrAddr = '0; rdAddr = '0; wrData = '0;
    dReset = 1'b0; dClr = 1'b0; dMemWrt = 1'b0; dRdEn = 1'b0;
    dWrAddr = '0; dRdAddr = '0; dWrData = '0;
    test_reset();
    test_reset_sweep();
    test_write_read();
    test_collision();
    test_back_to_back();
    test_runtime_clear();
    test_reset_mid_clear();
    test_clr_during_clear();
    test_param16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
